load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the core's MEM stage and Data_Memory; Data_Memory always moves 8 bytes on posedge clk.
//  Accepts RISC-V loads/stores of byte/half/word/double and drives the memory port.
//  Sign/zero-extends load data; sub-doubleword stores are done as a read-modify-write.
//  Range, alignment and encoding faults are reported with no memory access.
// PARAMETERS
//  MEM_BYTES    64  bytes in attached Data_Memory; valid address range is 0..MEM_BYTES-1
//  CHECK_ALIGN  1   1 = a non-naturally-aligned access faults; 0 = unaligned access allowed
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  req_valid    in   1   request present; stays stable until accepted
//  req_ready    out  1   1 only in IDLE; accept = req_valid & req_ready at posedge
//  req_write    in   1   1 = store, 0 = load
//  req_funct3   in   3   RISC-V funct3 (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU)
//  req_addr     in   64  byte address
//  req_wdata    in   64  store data, right-aligned
//  resp_valid   out  1   one-cycle pulse: request complete
//  resp_rdata   out  64  extended load data; 0 for stores and faults
//  resp_fault   out  1   qualifies resp_valid: request rejected, memory untouched
//  Mem_Addr     out  64  to Data_Memory
//  Write_Data   out  64  to Data_Memory
//  MemWrite     out  1   to Data_Memory
//  MemRead      out  1   to Data_Memory
//  Read_Data    in   64  from Data_Memory; valid the cycle after a MemRead cycle
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; all outputs 0 except req_ready=1; latched request cleared.
//  Size n from funct3[1:0]: 1/2/4/8 bytes. funct3[2]=1 means zero-extend (loads only).
//  Fault at accept if any of:
//   - funct3=111
//   - store with funct3[2]=1
//   - addr+n > MEM_BYTES (compute in 65 bits, no wrap)
//   - CHECK_ALIGN=1 and addr mod n != 0
//  Fault path: no memory strobe; registers resp_valid=1, resp_fault=1, resp_rdata=0; stays in IDLE.
//  States: IDLE, READ, EXTRACT, MERGE, WRITE
//   IDLE    -> READ    accept of a load, or a store with n<8
//   IDLE    -> WRITE   accept of a store with n=8
//   READ    -> EXTRACT load;   READ drives MemRead=1, Mem_Addr=addr
//   READ    -> MERGE   store
//   EXTRACT -> IDLE    resp_rdata = extend(Read_Data[8n-1:0]); resp_valid=1
//   MERGE   -> IDLE    MemWrite=1; Write_Data = {Read_Data[63:8n], wdata[8n-1:0]}; resp_valid=1
//   WRITE   -> IDLE    MemWrite=1; Write_Data=wdata; resp_valid=1
//  MemRead/MemWrite are decoded from registered state only and are never both 1.
//  In IDLE, Mem_Addr/Write_Data = 0.
//  Bytes above 8n that fall beyond MEM_BYTES-1 are don't-care.
//  resp_* are registered on the edge that enters IDLE and are held for exactly one cycle.
//  A new request may be accepted in the same cycle resp_valid=1.
//  Latency, accept edge to resp_valid cycle:
//   - LD / sub-dword load / sub-dword store: 3 edges
//   - SD: 2 edges
//   - fault: 1 edge
//  req_valid while busy: ignored (req_ready=0); requester must hold the request.
//  Reset mid-operation: MemWrite drops immediately and no partial write commits.
//   No resp_valid is issued for the aborted request.
// TESTING
//  After reset (memory init 0x0D), LD @0 -> resp_rdata=0x0D0D0D0D0D0D0D0D, resp_valid 3 edges after accept.
//  SB 0x80 @5; LB @5 -> 0xFFFFFFFFFFFFFF80; LBU @5 -> 0x80; LD @0 -> 0x0D0D800D0D0D0D0D.
//  SD 0x1122334455667788 @8 (2-edge latency); LW @8 -> 0x55667788; LH @12 -> 0x3344; LWU @12 -> 0x11223344.
//  Faults, each giving resp_fault=1 1 edge after accept and MemRead/MemWrite never 1:
//   LD @60; LW @2 (CHECK_ALIGN=1); funct3=111; store funct3=100.
//  SH 0xBEEF @16 with reset_n pulled low during the MERGE cycle -> no write, no resp;
//   after reset, LD @16 -> 0x0D0D0D0D0D0D0D0D.
//  Back-to-back LD @0 then LD @8 with req_valid held -> req_ready=0 while busy;
//   2nd request accepted in the cycle resp_valid=1 for the 1st.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and an 8-byte-wide Data_Memory.
// Loads are extended, sub-doubleword stores go through read-modify-write, bad requests fault without touching memory.
module load_store_unit #(
  parameter int MEM_BYTES   = 64,
  parameter bit CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data
);

  typedef enum logic [2:0] {IDLE, READ, EXTRACT, MERGE, WRITE} state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  state_t      state, state_n;
  req_t        lat;
  logic        accept, fault;
  logic [3:0]  req_bytes;
  logic [64:0] req_end;
  logic        misalign;
  logic [7:0]  byte_en;
  logic [63:0] data_mask;
  logic [63:0] load_ext;
  logic        sx;

  // Request decode: the end address is formed in 65 bits so a huge address cannot wrap into range.
  assign accept    = req_valid && req_ready;
  assign req_bytes = 4'd1 << req_funct3[1:0];
  assign req_end   = {1'b0, req_addr} + 65'(req_bytes);
  assign misalign  = (req_addr[2:0] & (req_bytes[2:0] - 3'd1)) != 3'd0;
  assign fault     = (req_funct3 == 3'b111) || (req_write && req_funct3[2]) ||
                     (req_end > 65'(MEM_BYTES)) || (CHECK_ALIGN && misalign);

  always_comb begin
    case (lat.funct3[1:0])
      2'd0:    byte_en = 8'h01;
      2'd1:    byte_en = 8'h03;
      2'd2:    byte_en = 8'h0F;
      default: byte_en = 8'hFF;
    endcase
  end

  for (genvar i = 0; i < 8; i++) begin : g_mask
    assign data_mask[8*i +: 8] = {8{byte_en[i]}};
  end

  assign sx = ~lat.funct3[2];

  always_comb begin
    case (lat.funct3[1:0])
      2'd0:    load_ext = {{56{sx & Read_Data[7]}},  Read_Data[7:0]};
      2'd1:    load_ext = {{48{sx & Read_Data[15]}}, Read_Data[15:0]};
      2'd2:    load_ext = {{32{sx & Read_Data[31]}}, Read_Data[31:0]};
      default: load_ext = Read_Data;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && !fault)
                 state_n = (req_write && req_funct3[1:0] == 2'd3) ? WRITE : READ;
      READ:    state_n = lat.write ? MERGE : EXTRACT;
      EXTRACT: state_n = IDLE;
      MERGE:   state_n = IDLE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Memory strobes come from registered state only, so an async reset kills them at once.
  always_comb begin
    req_ready  = (state == IDLE);
    MemRead    = (state == READ);
    MemWrite   = (state == MERGE) || (state == WRITE);
    Mem_Addr   = (state == IDLE) ? 64'd0 : lat.addr;
    Write_Data = 64'd0;
    if (state == MERGE) Write_Data = (Read_Data & ~data_mask) | (lat.wdata & data_mask);
    if (state == WRITE) Write_Data = lat.wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat        <= '0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= 64'd0;
    end else begin
      state      <= state_n;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= 64'd0;
      case (state)
        IDLE: if (accept) begin
          if (fault) begin
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
          end else begin
            lat <= '{write: req_write, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
          end
        end
        EXTRACT: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_ext;
        end
        MERGE, WRITE: resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array Data_Memory, a spec-level request model with a scoreboard queue,
// and directed vectors with literal expectations.
module tb_load_store_unit;
  localparam int MEM_BYTES   = 64;
  localparam bit CHECK_ALIGN = 1;

  logic        clk = 0, reset_n = 0;
  logic        req_valid = 0, req_ready, req_write = 0;
  logic [2:0]  req_funct3 = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_fault;
  logic [63:0] resp_rdata, Mem_Addr, Write_Data, Read_Data = 0;
  logic        MemWrite, MemRead;

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .CHECK_ALIGN(CHECK_ALIGN)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .MemWrite(MemWrite), .MemRead(MemRead),
    .Read_Data(Read_Data));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Data_Memory: 8 bytes at Mem_Addr per edge, bytes past the end ignored / read as 0.
  logic [7:0] mem [MEM_BYTES];
  initial for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h0D;

  always @(posedge clk) begin
    logic [63:0] rd;
    if (MemWrite)
      for (int i = 0; i < 8; i++)
        if (Mem_Addr + 64'(i) < 64'(MEM_BYTES)) mem[int'(Mem_Addr) + i] = Write_Data[8*i +: 8];
    if (MemRead) begin
      rd = 0;
      for (int i = 0; i < 8; i++)
        if (Mem_Addr + 64'(i) < 64'(MEM_BYTES)) rd[8*i +: 8] = mem[int'(Mem_Addr) + i];
      Read_Data <= rd;
    end
  end

  // Reference model: expected memory contents and per-request outcome.
  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [63:0] a, d, rdata;
    logic        fault;
    int          n, lat, due;
  } ent_t;

  logic [7:0] exp_mem [MEM_BYTES];
  initial for (int i = 0; i < MEM_BYTES; i++) exp_mem[i] = 8'h0D;

  ent_t exp_q[$];
  bit   busy = 0;
  int   cyc = 0, strobes = 0, last_lat = 0;
  logic [63:0] last_rdata = 0;
  logic        last_fault = 0;
  bit          b2b = 0;

  function automatic ent_t model(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    ent_t e;
    logic [64:0] endp;
    logic [63:0] raw;
    e.w = w; e.f3 = f3; e.a = a; e.d = d; e.rdata = 0; e.due = 0;
    e.n  = 1 << f3[1:0];
    endp = {1'b0, a} + 65'(e.n);
    e.fault = (f3 == 3'b111) || (w && f3[2]) || (endp > 65'(MEM_BYTES)) ||
              (CHECK_ALIGN && (a % 64'(e.n) != 0));
    if (e.fault) e.lat = 1;
    else if (w) e.lat = (e.n == 8) ? 2 : 3;
    else begin
      e.lat = 3;
      raw = 0;
      for (int i = 0; i < e.n; i++) raw = raw | (64'(exp_mem[int'(a) + i]) << (8*i));
      if (!f3[2] && e.n < 8 && raw[8*e.n-1]) raw = raw | (~64'd0 << (8*e.n));
      e.rdata = raw;
    end
    return e;
  endfunction

  // Compare process: every falling edge.
  always @(negedge clk) begin
    ent_t e;
    cyc++;
    if (MemRead || MemWrite) strobes++;
    if (!reset_n) begin
      exp_q.delete();
      busy = 0;
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_resp", 64'(resp_valid), 64'd0);
      chk("rst_strobe", 64'({MemRead, MemWrite}), 64'd0);
    end else begin
      chk("rd_wr_both", 64'(MemRead & MemWrite), 64'd0);
      if (resp_valid) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("rdata", resp_rdata, e.rdata);
          chk("fault", 64'(resp_fault), 64'(e.fault));
          chk("latency", 64'(cyc), 64'(e.due));
          last_rdata = resp_rdata; last_fault = resp_fault; last_lat = e.lat - (e.due - cyc);
          if (e.w && !e.fault)
            for (int i = 0; i < e.n; i++) exp_mem[int'(e.a) + i] = e.d[8*i +: 8];
          busy = 0;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        chk("resp_timeout", 64'(resp_valid), 64'd1);
        void'(exp_q.pop_front());
        busy = 0;
      end
      chk("ready", 64'(req_ready), 64'(!busy));
      if (req_ready) begin
        chk("idle_strobe", 64'({MemRead, MemWrite}), 64'd0);
        chk("idle_addr", Mem_Addr, 64'd0);
        chk("idle_wdata", Write_Data, 64'd0);
      end
      if (req_valid && req_ready) begin
        e = model(req_write, req_funct3, req_addr, req_wdata);
        e.due = cyc + e.lat;
        exp_q.push_back(e);
        busy = !e.fault;
      end
    end
  end

  task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    bit ok = 0;
    req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 64'(req_ready), 64'd1);
    else if (b2b) chk("b2b_accept_with_resp", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic op(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    issue(w, f3, a, d);
    wait_idle();
  endtask

  initial begin
    int s0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_rdata", resp_rdata, 64'd0);
    chk("reset_strobes", 64'({MemRead, MemWrite}), 64'd0);
    chk("reset_addr", Mem_Addr, 64'd0);
    reset_n = 1;
    @(posedge clk); #1;

    op(0, 3'b011, 0, 0);           chk("ld0", last_rdata, 64'h0D0D0D0D0D0D0D0D); chk("ld_lat", 64'(last_lat), 64'd3);
    op(1, 3'b000, 5, 64'h80);      chk("sb_lat", 64'(last_lat), 64'd3);
    op(0, 3'b000, 5, 0);           chk("lb5", last_rdata, 64'hFFFFFFFFFFFFFF80);
    op(0, 3'b100, 5, 0);           chk("lbu5", last_rdata, 64'h80);
    op(0, 3'b011, 0, 0);           chk("ld0_after_sb", last_rdata, 64'h0D0D800D0D0D0D0D);
    op(1, 3'b011, 8, 64'h1122334455667788); chk("sd_lat", 64'(last_lat), 64'd2);
    op(0, 3'b010, 8, 0);           chk("lw8", last_rdata, 64'h55667788);
    op(0, 3'b001, 12, 0);          chk("lh12", last_rdata, 64'h3344);
    op(0, 3'b110, 12, 0);          chk("lwu12", last_rdata, 64'h11223344);
    op(0, 3'b000, 63, 0);          chk("lb63_edge", last_rdata, 64'h0D);
    op(1, 3'b001, 62, 64'hFFFFA5F0); chk("sh62_edge_fault", 64'(last_fault), 64'd0);
    op(0, 3'b001, 62, 0);          chk("lh62", last_rdata, 64'hFFFFFFFFFFFFA5F0);

    s0 = strobes;
    op(0, 3'b011, 60, 0);          chk("ld60_fault", 64'(last_fault), 64'd1); chk("fault_lat", 64'(last_lat), 64'd1);
    op(0, 3'b010, 2, 0);           chk("lw2_misalign", 64'(last_fault), 64'd1);
    op(0, 3'b111, 0, 0);           chk("f3_111", 64'(last_fault), 64'd1);
    op(1, 3'b100, 0, 64'h55);      chk("store_unsigned", 64'(last_fault), 64'd1);
    chk("fault_strobes", 64'(strobes - s0), 64'd0);

    // Reset while the merge write is on the bus.
    issue(1, 3'b001, 16, 64'hBEEF);
    @(posedge clk); #1;
    chk("merge_memwrite", 64'(MemWrite), 64'd1);
    reset_n = 0; #1;
    chk("abort_memwrite", 64'(MemWrite), 64'd0);
    @(posedge clk); #1;
    reset_n = 1;
    repeat (3) @(posedge clk);
    #1;
    op(0, 3'b011, 16, 0);          chk("ld16_after_abort", last_rdata, 64'h0D0D0D0D0D0D0D0D);

    issue(0, 3'b011, 0, 0);
    b2b = 1;
    issue(0, 3'b011, 8, 0);
    b2b = 0;
    wait_idle();
    chk("b2b_ld8", last_rdata, 64'h1122334455667788);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
